// File: rtl/multi_phase_check.sv
// Multi-phase clock checker: measures the delay of NUM_CH shifted clocks relative to ref_in.
// Define PHASE_CHECK_LAST_DELAY_EN to keep and expose the last measured delay per channel.
module multi_phase_check #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned TOL    = 2,
    parameter int unsigned SETTLE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    locked,
    input  logic                    ref_in,
    input  logic [NUM_CH-1:0]       sh_in,
    input  logic [NUM_CH*CNT_W-1:0] exp_delay,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    clr_fail,
    output logic [NUM_CH-1:0]       fail,
    output logic                    any_fail,
    output logic [CNT_W-1:0]        period,
    output logic                    period_valid,
    output logic [NUM_CH-1:0]       meas_valid,
    output logic                    timeout,
    output logic [NUM_CH*CNT_W-1:0] last_delay
);

    localparam int unsigned      W1      = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   TOL_W   = W1'(TOL);

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_SETTLE,
        ST_RUN
    } state_t;

    state_t            state;
    logic [NUM_CH:0]   sync1, sync2, sync3, rise;
    logic              ref_edge;
    logic [NUM_CH-1:0] sh_edge;
    logic [CNT_W-1:0]  phase_cnt;
    logic [CNT_W-1:0]  settle_cnt;
    logic              armed;
    logic [1:0]        edge_cnt [NUM_CH];
    logic [CNT_W-1:0]  delay    [NUM_CH];
    logic [NUM_CH-1:0] bad;
    logic [NUM_CH-1:0] new_fail;
    logic              eval;
    logic              sat_hit;

    // Bit 0 carries ref_in so every path sees the same synchronizer latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= {sh_in, ref_in};
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise     = sync2 & ~sync3;
    assign ref_edge = rise[0];
    assign sh_edge  = rise[NUM_CH:1];
    assign any_fail = |fail;

    function automatic logic chan_bad(input logic [CNT_W-1:0] d,
                                      input logic [CNT_W-1:0] x,
                                      input logic [CNT_W-1:0] p,
                                      input logic [1:0]       n);
        logic [CNT_W:0] dd, xx, pp, e, alt;
        dd  = {1'b0, d};
        xx  = {1'b0, x};
        pp  = {1'b0, p};
        e   = (dd >= xx) ? dd - xx : xx - dd;
        alt = (pp >= e) ? pp - e : '0;
        if (alt < e) e = alt;
        return (n != 2'd1) || (x >= p) || (e > TOL_W);
    endfunction

    // In a ref-edge cycle phase_cnt still holds the length of the ending period.
    always_comb begin
        eval     = locked && (state == ST_RUN) && armed && ref_edge;
        sat_hit  = locked && (state != ST_DISABLED) && (phase_cnt == CNT_MAX) && !ref_edge;
        bad      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            bad[i] = chan_bad(delay[i], exp_delay[i*CNT_W +: CNT_W], phase_cnt, edge_cnt[i]);
        end
        new_fail = (eval ? (ch_en & bad) : '0) | (sat_hit ? ch_en : '0);
    end

    // phase_cnt is the phase of the current cycle except in a ref-edge cycle, whose
    // phase is 0; it therefore reloads to 1 so the following cycle reads phase 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_DISABLED;
            phase_cnt    <= '0;
            settle_cnt   <= '0;
            armed        <= 1'b0;
            fail         <= '0;
            timeout      <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            meas_valid   <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                edge_cnt[i] <= '0;
                delay[i]    <= '0;
            end
        end else begin
            if (ref_edge) begin
                phase_cnt <= CNT_W'(1);
            end else if (phase_cnt != CNT_MAX) begin
                phase_cnt <= phase_cnt + CNT_W'(1);
            end

            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (ref_edge) begin
                    edge_cnt[i] <= {1'b0, sh_edge[i]};
                    delay[i]    <= '0;
                end else if (sh_edge[i]) begin
                    if (edge_cnt[i] == 2'd0) delay[i] <= phase_cnt;
                    if (edge_cnt[i] != 2'd2) edge_cnt[i] <= edge_cnt[i] + 2'd1;
                end
            end

            fail       <= (clr_fail ? '0 : fail) | new_fail;
            timeout    <= (timeout && !clr_fail) || sat_hit;
            meas_valid <= eval ? ch_en : '0;

            if (!locked) begin
                state        <= ST_DISABLED;
                armed        <= 1'b0;
                settle_cnt   <= '0;
                period_valid <= 1'b0;
            end else begin
                case (state)
                    ST_DISABLED: begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                        armed      <= 1'b0;
                    end
                    ST_SETTLE: begin
                        if (sat_hit) begin
                            settle_cnt   <= '0;
                            period_valid <= 1'b0;
                        end else if (ref_edge) begin
                            period <= phase_cnt;
                            if (32'(settle_cnt) + 32'd1 >= SETTLE) begin
                                state <= ST_RUN;
                                armed <= 1'b0;
                            end else begin
                                settle_cnt <= settle_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_RUN: begin
                        if (sat_hit) begin
                            state        <= ST_SETTLE;
                            settle_cnt   <= '0;
                            armed        <= 1'b0;
                            period_valid <= 1'b0;
                        end else if (ref_edge) begin
                            period <= phase_cnt;
                            armed  <= 1'b1;
                            if (armed) period_valid <= 1'b1;
                        end
                    end
                    default: state <= ST_DISABLED;
                endcase
            end
        end
    end

`ifdef PHASE_CHECK_LAST_DELAY_EN
    logic [CNT_W-1:0] last_dly [NUM_CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) last_dly[i] <= '0;
        end else if (eval) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (ch_en[i]) last_dly[i] <= delay[i];
            end
        end
    end

    always_comb begin
        last_delay = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) last_delay[i*CNT_W +: CNT_W] = last_dly[i];
    end
`else
    assign last_delay = '0;
`endif

endmodule
